// File: rtl/sobel_window_gen_pkg.sv
// Shared definitions for the Sobel window generator: pixel width, window
// index order and the frame-tracking FSM states.
package sobel_pkg;
    localparam int PIX_W = 8;
    localparam int WIN_N = 9;

    // Window index order: row-major, top-left first
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ACTIVE
    } state_t;
endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bundle between a raster source, the window
// generator and the downstream gradient stage.
interface sobel_window_gen_if;
    import sobel_pkg::*;

    pix_t pixel_i;
    logic valid_i;
    pix_t data_0_o;
    pix_t data_1_o;
    pix_t data_2_o;
    pix_t data_3_o;
    pix_t data_4_o;
    pix_t data_5_o;
    pix_t data_6_o;
    pix_t data_7_o;
    pix_t data_8_o;
    logic done_o;
    logic frame_done_o;
    logic busy_o;

    modport master (
        output pixel_i, valid_i,
        input  data_0_o, data_1_o, data_2_o, data_3_o, data_4_o,
               data_5_o, data_6_o, data_7_o, data_8_o,
               done_o, frame_done_o, busy_o
    );

    modport slave (
        input  pixel_i, valid_i,
        output data_0_o, data_1_o, data_2_o, data_3_o, data_4_o,
               data_5_o, data_6_o, data_7_o, data_8_o,
               done_o, frame_done_o, busy_o
    );
endinterface

// File: rtl/sobel_window_gen_line_buffer.sv
// One-line delay built on a circular RAM with a single pointer. The output
// is the pixel written DEPTH shifts ago, ready before the next shift.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    input  logic i_shift,
    input  pix_t i_pixel,
    output pix_t o_pixel
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pix_t           r_mem [DEPTH];
    pix_t           r_rd;
    logic [AW-1:0]  r_ptr;
    logic [AW-1:0]  w_ptr_next;
    logic [AW-1:0]  w_rd_addr;

    always_comb begin
        w_ptr_next = (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
        // Prefetch the slot about to be overwritten so the oldest pixel is
        // presented while the new one is still being written.
        w_rd_addr  = sys_rst_i ? '0 : (i_shift ? w_ptr_next : r_ptr);
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_ptr <= '0;
        end else if (i_shift) begin
            r_ptr <= w_ptr_next;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (i_shift) begin
            r_mem[r_ptr] <= i_pixel;
        end
        r_rd <= r_mem[w_rd_addr];
    end

    assign o_pixel = r_rd;
endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to registered 3x3 neighbourhood for the gradient stage;
// interior pixels only, no border padding.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic               sys_clk_i,
    input  logic               sys_rst_i,
    sobel_window_gen_if.slave  s_if
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    state_t        r_state;
    state_t        w_state_next;
    logic          r_done;
    logic          r_frame_done;

    logic w_accept;
    logic w_col_last;
    logic w_row_last;
    logic w_emit;
    pix_t w_lb1;
    pix_t w_lb2;
    pix_t w_new [3];
    pix_t w_win [WIN_N];

    assign w_accept   = s_if.valid_i;
    assign w_col_last = (r_col == CW'(IMG_WIDTH - 1));
    assign w_row_last = (r_row == RW'(IMG_HEIGHT - 1));
    assign w_emit     = w_accept && (r_state == ACTIVE) && (r_col >= CW'(2));

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_col <= w_col_last ? '0 : r_col + 1'b1;
            if (w_col_last) begin
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = FILL;
            FILL:    if (w_accept && w_col_last && r_row == RW'(1)) w_state_next = ACTIVE;
            ACTIVE:  if (w_accept && w_col_last && w_row_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_done       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_done       <= w_emit;
            r_frame_done <= w_accept && w_col_last && w_row_last;
        end
    end

    sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .i_shift   (w_accept),
        .i_pixel   (s_if.pixel_i),
        .o_pixel   (w_lb1)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .i_shift   (w_accept),
        .i_pixel   (w_lb1),
        .o_pixel   (w_lb2)
    );

    assign w_new[0] = w_lb2;
    assign w_new[1] = w_lb1;
    assign w_new[2] = s_if.pixel_i;

    // Per window row: two-deep column history plus the incoming column
    // forms left/centre/right, captured into the output registers on emit.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            pix_t r_sr [2];
            pix_t r_l;
            pix_t r_c;
            pix_t r_r;

            always_ff @(posedge sys_clk_i) begin
                if (w_accept) begin
                    r_sr[0] <= r_sr[1];
                    r_sr[1] <= w_new[gi];
                end
            end

            always_ff @(posedge sys_clk_i) begin
                if (sys_rst_i) begin
                    r_l <= '0;
                    r_c <= '0;
                    r_r <= '0;
                end else if (w_emit) begin
                    r_l <= r_sr[0];
                    r_c <= r_sr[1];
                    r_r <= w_new[gi];
                end
            end

            assign w_win[gi*3 + 0] = r_l;
            assign w_win[gi*3 + 1] = r_c;
            assign w_win[gi*3 + 2] = r_r;
        end
    endgenerate

    assign s_if.data_0_o     = w_win[WIN_TL];
    assign s_if.data_1_o     = w_win[WIN_TC];
    assign s_if.data_2_o     = w_win[WIN_TR];
    assign s_if.data_3_o     = w_win[WIN_ML];
    assign s_if.data_4_o     = w_win[WIN_MC];
    assign s_if.data_5_o     = w_win[WIN_MR];
    assign s_if.data_6_o     = w_win[WIN_BL];
    assign s_if.data_7_o     = w_win[WIN_BC];
    assign s_if.data_8_o     = w_win[WIN_BR];
    assign s_if.done_o       = r_done;
    assign s_if.frame_done_o = r_frame_done;
    assign s_if.busy_o       = (r_state != IDLE);
endmodule
